// File: rtl/program_loader_if.sv
// Host-pin and RAM-write-port bundle for program_loader.
// The host or bench takes the master side; the loader takes the slave side.
interface program_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_mode;
    logic              strobe;
    logic [7:0]        byte_in;
    logic              ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic [7:0]        checksum;

    modport master (
        output load_mode, strobe, byte_in,
        input  ready, mem_addr, mem_data, mem_we, cpu_hold, done, checksum
    );

    modport slave (
        input  load_mode, strobe, byte_in,
        output ready, mem_addr, mem_data, mem_we, cpu_hold, done, checksum
    );
endinterface

// File: rtl/program_loader.sv
// Byte-serial loader: synchronizes host pins, writes one RAM byte per strobe pulse
// from address 0 upward, holds the CPU while loading, and keeps an 8-bit checksum.
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    program_loader_if.slave      bus,
    output logic [2:0]           o_dbg_state
);
    // Handshake: ready high means the next strobe rise will be taken; byte_in must be
    // held stable from before the strobe rise until ready returns high.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_STB = 3'd1,
        S_WRITE    = 3'd2,
        S_WAIT_LOW = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAM_BYTES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_lm_s1, r_lm_s;
    logic              r_s1, r_s2, r_s3;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic [7:0]        r_checksum;
    logic              r_done;

    logic w_rise, w_stb_lvl;
    logic w_ready, w_we, w_hold;
    logic w_load_start, w_capture, w_commit;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_stb_lvl = r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lm_s1 <= 1'b0;
            r_lm_s  <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
        end else begin
            r_lm_s1 <= bus.load_mode;
            r_lm_s  <= r_lm_s1;
            r_s1    <= bus.strobe;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_we         = 1'b0;
        w_hold       = 1'b0;
        w_load_start = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_lm_s) begin
                    w_next       = S_WAIT_STB;
                    w_load_start = 1'b1;
                end
            end
            S_WAIT_STB: begin
                w_hold  = 1'b1;
                w_ready = ~w_stb_lvl;
                // Abort is tested first so a coincident strobe rise never writes.
                if (!r_lm_s) begin
                    w_next = S_IDLE;
                end else if (w_rise) begin
                    w_next    = S_WRITE;
                    w_capture = 1'b1;
                end
            end
            S_WRITE: begin
                w_hold   = 1'b1;
                w_we     = 1'b1;
                w_commit = 1'b1;
                if (!r_lm_s)              w_next = S_IDLE;
                else if (r_count == LAST) w_next = S_DONE;
                else                      w_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                w_hold = 1'b1;
                if (!r_lm_s)        w_next = S_IDLE;
                else if (!w_stb_lvl) w_next = S_WAIT_STB;
            end
            S_DONE: begin
                w_hold = 1'b1;
                if (!r_lm_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_load_start) begin
                r_count    <= '0;
                r_checksum <= '0;
                r_done     <= 1'b0;
            end
            if (w_capture) begin
                r_mem_addr <= r_count[ADDR_W-1:0];
                r_mem_data <= bus.byte_in;
            end
            // An aborted WRITE still counts toward the partial checksum.
            if (w_commit) begin
                r_checksum <= r_checksum + r_mem_data;
                r_count    <= r_count + CNT_W'(1);
                if (w_next == S_DONE) r_done <= 1'b1;
            end
        end
    end

    assign bus.ready    = w_ready;
    assign bus.mem_we   = w_we;
    assign bus.cpu_hold = w_hold;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.done     = r_done;
    assign bus.checksum = r_checksum;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads,
// scored against an image/checksum model of what the host sent.
module tb_program_loader;
    localparam int RAM_BYTES = 16;
    localparam int AW        = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.RAM_BYTES(RAM_BYTES), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the RAM image and checksum should be after the bytes sent.
    logic [AW+7:0] exp_q[$];
    logic [7:0]    m_ram[RAM_BYTES];
    logic [7:0]    tb_ram[RAM_BYTES];
    int            m_count;
    int            m_sum;
    bit            m_done;

    task automatic model_start();
        m_count = 0;
        m_sum   = 0;
        m_done  = 0;
        exp_q.delete();
    endtask

    task automatic model_strobe(input logic [7:0] b);
        if (m_count < RAM_BYTES) begin
            exp_q.push_back({AW'(m_count), b});
            m_ram[m_count] = b;
            m_sum   = (m_sum + b) % 256;
            m_count = m_count + 1;
            m_done  = (m_count == RAM_BYTES);
        end
    endtask

    // Write monitor: every mem_we cycle must match the next expected write.
    bit prev_we = 0;
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            tb_ram[bus.mem_addr] = bus.mem_data;
            if (exp_q.size() == 0) begin
                check("unexpected_we", {bus.mem_addr, bus.mem_data}, 32'hFFFF_FFFF);
            end else begin
                check("write_addr_data", {bus.mem_addr, bus.mem_data}, exp_q.pop_front());
            end
        end
        prev_we = rst_n & bus.mem_we;
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.load_mode = 1'b0;
        bus.strobe    = 1'b0;
        bus.byte_in   = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic enter_load();
        @(negedge clk);
        bus.load_mode = 1'b1;
        model_start();
        repeat (2) @(negedge clk);
        check("hold_after_2_edges", {31'd0, bus.cpu_hold}, 32'd0);
        @(negedge clk);
        check("hold_after_3_edges", {31'd0, bus.cpu_hold}, 32'd1);
        check("load_done_cleared", {31'd0, bus.done}, 32'd0);
        check("load_sum_cleared", {24'd0, bus.checksum}, 32'd0);
    endtask

    task automatic leave_load();
        @(negedge clk);
        bus.load_mode = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_released", {31'd0, bus.cpu_hold}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo, input bit wait_rdy);
        if (wait_rdy) begin
            int n = 0;
            while (!bus.ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
        end
        model_strobe(b);
        bus.byte_in = b;
        bus.strobe  = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (i >= 2) check("ready_low_in_strobe", {31'd0, bus.ready}, 32'd0);
        end
        bus.strobe = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain_and_check();
        repeat (6) @(negedge clk);
        check("pending_writes", exp_q.size(), 32'd0);
        check("checksum", {24'd0, bus.checksum}, m_sum);
        check("done", {31'd0, bus.done}, {31'd0, m_done});
    endtask

    task automatic check_image();
        for (int i = 0; i < RAM_BYTES; i++) check("ram_image", {24'd0, tb_ram[i]}, {24'd0, m_ram[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sum_before;
        int         n;

        do_reset();
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {24'd0, bus.checksum}, 32'd0);
        check("rst_addr", {28'd0, bus.mem_addr}, 32'd0);
        check("rst_data", {24'd0, bus.mem_data}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);

        // Long strobe: one write only.
        enter_load();
        send_byte(8'hAB, 20, 3, 1'b1);
        drain_and_check();
        check("long_strobe_sum", {24'd0, bus.checksum}, 32'hAB);
        leave_load();

        // Full load of 0x01..0x10.
        enter_load();
        for (int i = 1; i <= RAM_BYTES; i++) send_byte(8'(i), 2, 2, 1'b1);
        drain_and_check();
        check("full_sum_const", {24'd0, bus.checksum}, 32'h88);
        check("full_done_const", {31'd0, bus.done}, 32'd1);
        check_image();

        // Overrun: strobes after done are ignored.
        sum_before = bus.checksum;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 2, 3, 1'b0);
        drain_and_check();
        check("overrun_addr", {28'd0, bus.mem_addr}, RAM_BYTES - 1);
        check("overrun_sum", {24'd0, bus.checksum}, {24'd0, sum_before});
        leave_load();
        check("done_kept_idle", {31'd0, bus.done}, 32'd1);
        check("sum_kept_idle", {24'd0, bus.checksum}, 32'h88);

        // Abort after 5 bytes of 0xFF, then reload.
        enter_load();
        for (int i = 0; i < 5; i++) send_byte(8'hFF, 2, 3, 1'b1);
        drain_and_check();
        leave_load();
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_sum", {24'd0, bus.checksum}, 32'hFB);

        // Randomized full load with random pulse widths.
        enter_load();
        for (int i = 0; i < RAM_BYTES; i++)
            send_byte(8'($urandom_range(0, 255)), $urandom_range(2, 6), $urandom_range(2, 6), 1'b1);
        drain_and_check();
        check_image();
        leave_load();

        // Checksum wrap.
        enter_load();
        for (int i = 0; i < RAM_BYTES; i++) send_byte(8'h80, 2, 2, 1'b1);
        drain_and_check();
        check("wrap_sum_const", {24'd0, bus.checksum}, 32'h00);
        check("wrap_done_const", {31'd0, bus.done}, 32'd1);
        leave_load();

        // Asynchronous reset in the middle of a write.
        enter_load();
        model_strobe(8'h5A);
        bus.byte_in = 8'h5A;
        bus.strobe  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.mem_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midwrite_we_seen", {31'd0, bus.mem_we}, 32'd1);
        #1;
        rst_n         = 1'b0;
        bus.strobe    = 1'b0;
        bus.load_mode = 1'b0;
        #1;
        check("arst_we", {31'd0, bus.mem_we}, 32'd0);
        check("arst_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("arst_ready", {31'd0, bus.ready}, 32'd0);
        check("arst_addr", {28'd0, bus.mem_addr}, 32'd0);
        check("arst_data", {24'd0, bus.mem_data}, 32'd0);
        check("arst_sum", {24'd0, bus.checksum}, 32'd0);
        check("arst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("post_rst_pending", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
